// File: rtl/rxpkt_pkg.sv
// Shared constants and state encoding for the lasernet receive packet engine.
package rxpkt_pkg;

    localparam int HDR_WORDS = 5;

    localparam int W_PORTS = 0;
    localparam int W_SEQ   = 1;
    localparam int W_ACK   = 2;
    localparam int W_FLAGS = 3;
    localparam int W_CSUM  = 4;

    localparam int FLAGS_HI = 24;
    localparam int FLAGS_LO = 16;

    localparam logic [7:0] BLANK_BYTE = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SUM    = 2'd1,
        ST_CHECK  = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

endpackage

// File: rtl/rxpkt_csum_acc.sv
// Serial 16-bit ones'-complement accumulator; end-around carry folded every cycle.
module rxpkt_csum_acc (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [15:0] din_i,
    output logic [15:0] sum_o
);

    logic [15:0] sum_q;
    logic [15:0] sum_d;
    logic [16:0] add;

    always_comb begin
        add   = {1'b0, sum_q} + {1'b0, din_i};
        sum_d = add[15:0] + {15'b0, add[16]};
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sum_q <= 16'h0000;
        end else if (clr_i) begin
            sum_q <= 16'h0000;
        end else if (en_i) begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/rxpkt_reassembly.sv
// Receive packet engine: serial checksum, ISN-relative sequencing, slot reassembly.
// Define RXPKT_OOO_BUF_EN to accept out-of-order in-window packets into their slots.
//
// state     | meaning
// ST_IDLE   | waiting for ready, packet/isn captured on strobe
// ST_SUM    | one halfword per cycle into the checksum accumulator
// ST_CHECK  | accumulator compared against 16'hFFFF
// ST_COMMIT | good packet: slot write, seq/ack/flags update
module rxpkt_reassembly
    import rxpkt_pkg::*;
#(
    parameter int DATA_WORDS = 4,
    parameter int NUM_SLOTS  = 5
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                ready_i,
    input  logic [31:0]                         isn_i,
    input  logic [32*(HDR_WORDS+DATA_WORDS)-1:0] packet_i,
    output logic                                busy_o,
    output logic [31:0]                         seq_o,
    output logic [31:0]                         ack_o,
    output logic [8:0]                          flags_o,
    output logic [NUM_SLOTS*DATA_WORDS*32-1:0]  message_o,
    output logic [NUM_SLOTS-1:0]                slot_valid_o,
    output logic                                complete_o,
    output logic                                pkt_good_o,
    output logic                                pkt_bad_o,
    output logic                                overrun_o
);

    localparam int PKT_WORDS = HDR_WORDS + DATA_WORDS;
    localparam int PKT_W     = 32 * PKT_WORDS;
    localparam int NUM_HW    = 2 * PKT_WORDS;
    localparam int HW_W      = $clog2(NUM_HW);
    localparam int SLOT_W    = DATA_WORDS * 32;
    localparam int MSG_W     = NUM_SLOTS * SLOT_W;
    localparam int EXP_W     = $clog2(NUM_SLOTS + 2);

    state_e               state_q;
    logic [PKT_W-1:0]     packet_q;
    logic [31:0]          isn_q;
    logic [HW_W-1:0]      hw_idx_q;
    logic [EXP_W-1:0]     expected_q, expected_d;
    logic [NUM_SLOTS-1:0] slot_valid_q, slot_valid_d;
    logic [MSG_W-1:0]     message_q, message_d;
    logic [31:0]          seq_q, ack_q;
    logic [8:0]           flags_q;
    logic                 busy_q, complete_q;
    logic                 pkt_good_q, pkt_bad_q, overrun_q;

    logic [15:0]          hw_sel;
    logic [15:0]          sum;
    logic [31:0]          seq_fld, ack_fld, rel;
    logic [8:0]           flags_fld;
    logic                 in_win, wr_en;

    rxpkt_csum_acc u_csum (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   ((state_q == ST_IDLE) && ready_i),
        .en_i    (state_q == ST_SUM),
        .din_i   (hw_sel),
        .sum_o   (sum)
    );

    always_comb begin
        hw_sel = 16'h0000;
        for (int k = 0; k < NUM_HW; k++) begin
            if (hw_idx_q == HW_W'(k)) hw_sel = packet_q[(NUM_HW-1-k)*16 +: 16];
        end
    end

    always_comb begin
        seq_fld   = packet_q[32*(PKT_WORDS-1-W_SEQ) +: 32];
        ack_fld   = packet_q[32*(PKT_WORDS-1-W_ACK) +: 32];
        flags_fld = packet_q[32*(PKT_WORDS-1-W_FLAGS)+FLAGS_LO +: FLAGS_HI-FLAGS_LO+1];
        // Unsigned modular difference: seq below isn lands far outside the window.
        rel       = seq_fld - isn_q;
        in_win    = (rel != 32'd0) && (rel <= 32'(NUM_SLOTS));
`ifdef RXPKT_OOO_BUF_EN
        wr_en     = in_win;
`else
        wr_en     = in_win && (rel == 32'(expected_q));
`endif
        message_d    = message_q;
        slot_valid_d = slot_valid_q;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (wr_en && (rel == 32'(k + 1))) begin
                message_d[k*SLOT_W +: SLOT_W] = packet_q[SLOT_W-1:0];
                slot_valid_d[k]               = 1'b1;
            end
        end
`ifdef RXPKT_OOO_BUF_EN
        expected_d = EXP_W'(NUM_SLOTS + 1);
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (!slot_valid_d[k]) expected_d = EXP_W'(k + 1);
        end
`else
        expected_d = wr_en ? expected_q + EXP_W'(1) : expected_q;
`endif
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            packet_q     <= '0;
            isn_q        <= 32'h0;
            hw_idx_q     <= '0;
            expected_q   <= EXP_W'(1);
            slot_valid_q <= '0;
            message_q    <= {(MSG_W/8){BLANK_BYTE}};
            seq_q        <= 32'h0;
            ack_q        <= 32'h0;
            flags_q      <= 9'h0;
            busy_q       <= 1'b0;
            complete_q   <= 1'b0;
            pkt_good_q   <= 1'b0;
            pkt_bad_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            pkt_good_q <= 1'b0;
            pkt_bad_q  <= 1'b0;
            overrun_q  <= ready_i && busy_q;
            case (state_q)
                ST_IDLE: begin
                    if (ready_i) begin
                        packet_q <= packet_i;
                        isn_q    <= isn_i;
                        hw_idx_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_SUM;
                    end
                end
                ST_SUM: begin
                    hw_idx_q <= hw_idx_q + HW_W'(1);
                    if (hw_idx_q == HW_W'(NUM_HW - 1)) state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (sum == 16'hFFFF) begin
                        state_q <= ST_COMMIT;
                    end else begin
                        pkt_bad_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_COMMIT: begin
                    ack_q        <= ack_fld;
                    flags_q      <= flags_fld;
                    if (wr_en) seq_q <= seq_fld;
                    message_q    <= message_d;
                    slot_valid_q <= slot_valid_d;
                    complete_q   <= &slot_valid_d;
                    expected_q   <= expected_d;
                    pkt_good_q   <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign seq_o        = seq_q;
    assign ack_o        = ack_q;
    assign flags_o      = flags_q;
    assign message_o    = message_q;
    assign slot_valid_o = slot_valid_q;
    assign complete_o   = complete_q;
    assign pkt_good_o   = pkt_good_q;
    assign pkt_bad_o    = pkt_bad_q;
    assign overrun_o    = overrun_q;

endmodule
